// File: rtl/wb_port_arbiter_if.sv
// Register-file write port bundle: core and microcode write requests in,
// register-file write port and FIFO occupancy out.
interface wb_port_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              core_valid;
  logic              core_ready;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_data;
  logic              uc_valid;
  logic              uc_ready;
  logic [ADDR_W-1:0] uc_addr;
  logic [DATA_W-1:0] uc_data;
  logic              flush;
  logic              rf_we;
  logic              rf_rom_sel;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  fifo_count;

  modport slave (
    input  core_valid, core_addr, core_data, uc_valid, uc_addr, uc_data, flush,
    output core_ready, uc_ready, rf_we, rf_rom_sel, rf_waddr, rf_wdata, fifo_count
  );

  modport master (
    output core_valid, core_addr, core_data, uc_valid, uc_addr, uc_data, flush,
    input  core_ready, uc_ready, rf_we, rf_rom_sel, rf_waddr, rf_wdata, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between core writeback and a FIFO of
// microcode writes. Optional grant statistics under WB_PORT_ARB_STATS_EN.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
`ifdef WB_PORT_ARB_STATS_EN
  output logic [15:0]       o_core_grant_cnt,
  output logic [15:0]       o_uc_grant_cnt,
  output logic [15:0]       o_force_cnt,
`endif
  wb_port_arbiter_if.slave  bus
);
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, CORE, UC} grant_t;

  grant_t              r_state;
  grant_t              w_grant;
  logic [ADDR_W-1:0]   r_mem_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic [STARVE_W-1:0] r_starve;
  logic                r_rom_sel;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;

  logic w_nonempty;
  logic w_full;
  logic w_force;
  logic w_push;
  logic w_pop;

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  // A flush cycle never grants UC, so it cannot force either.
  assign w_force    = w_nonempty && (r_starve == STARVE_W'(STARVE_MAX)) && !bus.flush;
  assign w_push     = bus.uc_valid && !w_full && !bus.flush;
  assign w_pop      = (w_grant == UC);

  always_comb begin
    w_grant = IDLE;
    if (w_force)
      w_grant = UC;
    else if (bus.core_valid)
      w_grant = CORE;
    else if (w_nonempty && !bus.flush)
      w_grant = UC;
  end

  assign bus.core_ready = !w_force;
  assign bus.uc_ready   = !w_full;
  assign bus.fifo_count = r_count;
  assign bus.rf_we      = (r_state != IDLE);
  assign bus.rf_rom_sel = r_rom_sel;
  assign bus.rf_waddr   = r_waddr;
  assign bus.rf_wdata   = r_wdata;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wptr] <= bus.uc_addr;
      r_mem_data[r_wptr] <= bus.uc_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rom_sel <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_starve  <= '0;
    end else begin
      r_state <= w_grant;
      case (w_grant)
        CORE: begin
          r_rom_sel <= 1'b0;
          r_waddr   <= bus.core_addr;
          r_wdata   <= bus.core_data;
        end
        UC: begin
          r_rom_sel <= 1'b1;
          r_waddr   <= r_mem_addr[r_rptr];
          r_wdata   <= r_mem_data[r_rptr];
        end
        default: ;
      endcase

      if (bus.flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end

      // Starvation only accrues while microcode work is actually waiting.
      if (bus.flush || (w_grant == UC) || !w_nonempty)
        r_starve <= '0;
      else if ((w_grant == CORE) && (r_starve != STARVE_W'(STARVE_MAX)))
        r_starve <= r_starve + STARVE_W'(1);
    end
  end

`ifdef WB_PORT_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_core_grant_cnt <= '0;
      o_uc_grant_cnt   <= '0;
      o_force_cnt      <= '0;
    end else begin
      if ((w_grant == CORE) && (o_core_grant_cnt != 16'hFFFF))
        o_core_grant_cnt <= o_core_grant_cnt + 16'd1;
      if ((w_grant == UC) && (o_uc_grant_cnt != 16'hFFFF))
        o_uc_grant_cnt <= o_uc_grant_cnt + 16'd1;
      if (w_force && (o_force_cnt != 16'hFFFF))
        o_force_cnt <= o_force_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised and directed bench for wb_port_arbiter against a queue-based
// reference model of the arbitration rules.
module tb_wb_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;
  localparam int SMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) bus ();

`ifdef WB_PORT_ARB_STATS_EN
  logic [15:0] core_cnt, uc_cnt, force_cnt;
  int mc_core = 0, mc_uc = 0, mc_force = 0;
`endif

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
`ifdef WB_PORT_ARB_STATS_EN
    .o_core_grant_cnt (core_cnt),
    .o_uc_grant_cnt   (uc_cnt),
    .o_force_cnt      (force_cnt),
`endif
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [AW+DW-1:0] mq[$];
  int               m_starve = 0;
  logic             m_we = 1'b0, m_rom = 1'b0;
  logic [AW-1:0]    m_addr = '0;
  logic [DW-1:0]    m_data = '0;

  logic             last_cr;
  bit               cap_en = 1'b0;
  logic [DW-1:0]    cap[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_we = 1'b0; m_rom = 1'b0; m_addr = '0; m_data = '0;
`ifdef WB_PORT_ARB_STATS_EN
    mc_core = 0; mc_uc = 0; mc_force = 0;
`endif
  endtask

  // One clock: drive at edge+1, compare mid-cycle, advance model, return at next edge+1.
  task automatic cycle(input logic cv, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic uv, input logic [AW-1:0] ua, input logic [DW-1:0] ud,
                       input logic fl);
    int sz;
    logic frc, gc, gu;
    bus.core_valid = cv; bus.core_addr = ca; bus.core_data = cd;
    bus.uc_valid = uv;   bus.uc_addr = ua;   bus.uc_data = ud;
    bus.flush = fl;
    #4;
    sz  = mq.size();
    frc = (sz > 0) && (m_starve == SMAX) && !fl;
    chk("core_ready", bus.core_ready, !frc);
    chk("uc_ready", bus.uc_ready, sz < DEPTH);
    chk("fifo_count", bus.fifo_count, sz);
    chk("rf_we", bus.rf_we, m_we);
    chk("rf_rom_sel", bus.rf_rom_sel, m_rom);
    chk("rf_waddr", bus.rf_waddr, m_addr);
    chk("rf_wdata", bus.rf_wdata, m_data);
`ifdef WB_PORT_ARB_STATS_EN
    chk("core_grant_cnt", core_cnt, mc_core);
    chk("uc_grant_cnt", uc_cnt, mc_uc);
    chk("force_cnt", force_cnt, mc_force);
`endif
    last_cr = bus.core_ready;
    gc = cv && !frc;
    gu = !fl && (sz > 0) && (frc || !cv);
    if (gc) begin
      m_we = 1'b1; m_rom = 1'b0; m_addr = ca; m_data = cd;
    end else if (gu) begin
      m_we = 1'b1; m_rom = 1'b1; {m_addr, m_data} = mq[0];
    end else
      m_we = 1'b0;
`ifdef WB_PORT_ARB_STATS_EN
    if (gc && mc_core < 16'hFFFF) mc_core++;
    if (gu && mc_uc < 16'hFFFF) mc_uc++;
    if (frc && mc_force < 16'hFFFF) mc_force++;
`endif
    if (fl || gu || sz == 0) m_starve = 0;
    else if (gc && m_starve < SMAX) m_starve++;
    if (fl) mq.delete();
    else begin
      if (gu) void'(mq.pop_front());
      if (uv && sz < DEPTH) mq.push_back({ua, ud});
    end
    @(posedge clk); #1;
    if (cap_en && bus.rf_we && bus.rf_rom_sel) cap.push_back(bus.rf_wdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.core_valid = 1'b0; bus.core_addr = '0; bus.core_data = '0;
    bus.uc_valid = 1'b0;   bus.uc_addr = '0;   bus.uc_data = '0;
    bus.flush = 1'b0;
    #2;
    chk("reset_rf_we", bus.rf_we, 1'b0);
    chk("reset_fifo_count", bus.fifo_count, 0);
    chk("reset_rf_wdata", bus.rf_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single microcode write, retired two cycles after push
    cycle(1'b0, '0, '0, 1'b1, 5'd3, 32'h1234, 1'b0);
    chk("t1_count", bus.fifo_count, 1);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    chk("t1_we", bus.rf_we, 1'b1);
    chk("t1_rom", bus.rf_rom_sel, 1'b1);
    chk("t1_addr", bus.rf_waddr, 5'd3);
    chk("t1_data", bus.rf_wdata, 32'h1234);
    idle(2);

    // Core held busy while two uc entries queue up; starvation forces one UC slot
    cycle(1'b1, 5'd7, 32'hAAAA0000, 1'b1, 5'd10, 32'hC0DE0001, 1'b0);
    cycle(1'b1, 5'd7, 32'hAAAA0000, 1'b1, 5'd11, 32'hC0DE0002, 1'b0);
    cycle(1'b1, 5'd7, 32'hAAAA0000, 1'b0, '0, '0, 1'b0);
    chk("t2_cr0", last_cr, 1'b1);
    cycle(1'b1, 5'd7, 32'hAAAA0000, 1'b0, '0, '0, 1'b0);
    chk("t2_cr1", last_cr, 1'b1);
    cycle(1'b1, 5'd7, 32'hAAAA0000, 1'b0, '0, '0, 1'b0);
    chk("t2_force_cr", last_cr, 1'b0);
    chk("t2_force_data", bus.rf_wdata, 32'hC0DE0001);
    chk("t2_force_rom", bus.rf_rom_sel, 1'b1);
    cycle(1'b1, 5'd7, 32'hAAAA0000, 1'b0, '0, '0, 1'b0);
    chk("t2_resume_cr", last_cr, 1'b1);
    chk("t2_resume_data", bus.rf_wdata, 32'hAAAA0000);
`ifdef WB_PORT_ARB_STATS_EN
    chk("t2_force_cnt", force_cnt, 16'd1);
`endif
    idle(4);

    // Fill the FIFO behind a busy core; a fifth push is held off
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 5'd1, 32'h11110000 + i, 1'b1, 5'(i), 32'h20 + i, 1'b0);
    chk("t3_full_count", bus.fifo_count, 4);
    chk("t3_full_ready", bus.uc_ready, 1'b0);
    cycle(1'b1, 5'd1, 32'h11119999, 1'b1, 5'd9, 32'hDEAD, 1'b0);
    chk("t3_after_pop_ready", bus.uc_ready, 1'b1);
    chk("t3_after_pop_count", bus.fifo_count, 3);
    idle(6);

    // Flush with a concurrent push: everything discarded
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 5'd2, 32'h3000 + i, 1'b1, 5'd4, 32'h4000 + i, 1'b0);
    chk("t4_queued", bus.fifo_count, 3);
    cycle(1'b0, '0, '0, 1'b1, 5'd5, 32'h5000, 1'b1);
    chk("t4_flushed", bus.fifo_count, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      chk("t4_no_uc_write", bus.rf_we & bus.rf_rom_sel, 1'b0);
    end

    // Asynchronous reset between clock edges mid-burst
    cycle(1'b1, 5'd6, 32'h6000, 1'b1, 5'd8, 32'h8000, 1'b0);
    cycle(1'b1, 5'd6, 32'h6001, 1'b1, 5'd8, 32'h8001, 1'b0);
    #2;
    bus.core_valid = 1'b0; bus.uc_valid = 1'b0; bus.flush = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_we", bus.rf_we, 1'b0);
    chk("t5_rst_count", bus.fifo_count, 0);
    model_reset();
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    cycle(1'b1, 5'd9, 32'h5A5A, 1'b0, '0, '0, 1'b0);
    chk("t5_first_we", bus.rf_we, 1'b1);
    chk("t5_first_addr", bus.rf_waddr, 5'd9);
    chk("t5_first_data", bus.rf_wdata, 32'h5A5A);
    idle(2);

    // Ten sequential microcode writes through the wrapping pointers
    cap.delete();
    cap_en = 1'b1;
    for (int i = 0; i < 10; i++)
      cycle(1'b0, '0, '0, 1'b1, 5'(i), 32'(i), 1'b0);
    idle(3);
    cap_en = 1'b0;
    chk("t6_len", cap.size(), 10);
    for (int i = 0; i < cap.size() && i < 10; i++)
      chk("t6_order", cap[i], 32'(i));

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 99) < 55), 5'($urandom), $urandom,
            1'($urandom_range(0, 99) < 60), 5'($urandom), $urandom,
            1'($urandom_range(0, 31) == 0));
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
